// File: rtl/adder_arbiter.sv
// Round-robin arbiter and sequencer that shares one registered-operand adder among NREQ
// requesters. It returns each sum tagged with the requester index over a valid/ready port.
module adder_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ADD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_a,
   input  logic [NREQ*WIDTH-1:0]    req_b,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   input  logic [WIDTH-1:0]         add_c,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     busy
);

   localparam int unsigned IDW  = $clog2(NREQ);
   localparam int unsigned CNTW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [CNTW-1:0] CNT_INIT = CNTW'(ADD_LAT - 1);
   localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);

   logic [1:0]       state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [WIDTH-1:0] add_a_q, add_a_d;
   logic [WIDTH-1:0] add_b_q, add_b_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   cand;
   logic             accept;

   // Search starts one past the last winner and wraps, so every requester is eventually served.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         cand = IDW'((int'(last_q) + k) % int'(NREQ));
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign accept    = (state_q == IDLE) && gnt_found;
   assign req_ready = (accept && rst_n) ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      rsp_id_d  = rsp_id_q;
      rsp_sum_d = rsp_sum_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               add_a_d  = req_a[gnt_idx*WIDTH +: WIDTH];
               add_b_d  = req_b[gnt_idx*WIDTH +: WIDTH];
               rsp_id_d = gnt_idx;
               last_d   = gnt_idx;
               cnt_d    = CNT_INIT;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNTW'(1);
            end else begin
               rsp_sum_d = add_c;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= LAST_RST;
         add_a_q   <= '0;
         add_b_q   <= '0;
         rsp_id_q  <= '0;
         rsp_sum_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         rsp_id_q  <= rsp_id_d;
         rsp_sum_q <= rsp_sum_d;
      end
   end

   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level reference model, directed scenarios, random traffic,
// plus an ADD_LAT=3 instance against a slow adder and an ADD_LAT=1 instance against the same adder.
module tb_adder_arbiter;

   localparam int W = 16;
   localparam int N = 4;
   localparam int LAT = 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid, req_ready;
   logic [N*W-1:0]   req_a, req_b;
   logic [W-1:0]     add_a, add_b, add_c;
   logic             rsp_valid, rsp_ready, busy;
   logic [1:0]       rsp_id;
   logic [W-1:0]     rsp_sum;

   // Shared stimulus for the slow-adder instances
   logic [N-1:0]     r3_valid, r3_ready, db_ready;
   logic [N*W-1:0]   r3_a, r3_b;
   logic [W-1:0]     a3, b3, c3, ab, bb, cb;
   logic             rsp3_valid, db_valid, busy3, db_busy;
   logic             rsp3_ready, db_rsp_ready;
   logic [1:0]       rsp3_id, db_id;
   logic [W-1:0]     rsp3_sum, db_sum;
   logic [W-1:0]     p3_0, p3_1, pb_0, pb_1;

   always #5 clk = ~clk;

   adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_c(add_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .busy(busy)
   );

   adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready),
      .req_a(r3_a), .req_b(r3_b), .add_a(a3), .add_b(b3), .add_c(c3),
      .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_id(rsp3_id), .rsp_sum(rsp3_sum),
      .busy(busy3)
   );

   adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(1)) dut_bad (
      .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(db_ready),
      .req_a(r3_a), .req_b(r3_b), .add_a(ab), .add_b(bb), .add_c(cb),
      .rsp_valid(db_valid), .rsp_ready(db_rsp_ready), .rsp_id(db_id), .rsp_sum(db_sum),
      .busy(db_busy)
   );

   assign add_c = add_a + add_b;

   // Adder whose sum is valid at the third edge after its operands change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p3_0 <= '0;
         p3_1 <= '0;
         pb_0 <= '0;
         pb_1 <= '0;
      end else begin
         p3_0 <= a3 + b3;
         p3_1 <= p3_0;
         pb_0 <= ab + bb;
         pb_1 <= pb_0;
      end
   end
   assign c3 = p3_1;
   assign cb = pb_1;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: 0 idle, 1 waiting on the adder, 2 holding a response
   int          m_st, m_wait, m_last, m_id, m_gnt;
   logic [W-1:0] m_a, m_b, m_sum;
   logic [31:0] rsp_log[$];
   bit          drop_on_grant;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_st = 0; m_wait = 0; m_last = N - 1; m_id = 0; m_gnt = -1;
      m_a = '0; m_b = '0; m_sum = '0;
   endtask

   // One cycle: compare at negedge, advance the model, step past posedge.
   task automatic tick();
      int g;
      logic [N-1:0] er;
      @(negedge clk);
      g  = (m_st == 0) ? pick(req_valid, m_last) : -1;
      er = (g >= 0) ? (N'(1) << g) : '0;
      check("req_ready", 32'(req_ready), 32'(er));
      check("busy", 32'(busy), 32'(m_st != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
      check("add_a", 32'(add_a), 32'(m_a));
      check("add_b", 32'(add_b), 32'(m_b));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
      if (rsp_valid && rsp_ready) rsp_log.push_back({16'(rsp_id), rsp_sum});
      m_gnt = g;
      case (m_st)
         0: if (g >= 0) begin
               m_a = req_a[g*W +: W];
               m_b = req_b[g*W +: W];
               m_id = g; m_last = g; m_wait = LAT; m_st = 1;
            end
         1: begin
               m_wait--;
               if (m_wait == 0) begin
                  m_sum = W'((int'(m_a) + int'(m_b)) % 65536);
                  m_st = 2;
               end
            end
         default: if (rsp_ready) m_st = 0;
      endcase
      @(posedge clk);
      #1;
      if (drop_on_grant && m_gnt >= 0) req_valid[m_gnt[1:0]] = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_add_a", 32'(add_a), 32'h0);
      check("rst_add_b", 32'(add_b), 32'h0);
      check("rst_rsp_sum", 32'(rsp_sum), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i[1:0]] = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] e;
      int t_acc, t_rsp, t_bad;
      logic [W-1:0] s3, sbad, exp3;
      logic [1:0] id3;

      rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      r3_valid = '0; r3_a = '0; r3_b = '0; rsp3_ready = 1'b1; db_rsp_ready = 1'b1;
      drop_on_grant = 1'b1;
      model_reset();
      #2;
      apply_reset();

      // Single request from requester 2
      rsp_log.delete();
      set_op(2, 16'h0003, 16'h0004);
      repeat (5) tick();
      check("single_count", 32'(rsp_log.size()), 32'd1);
      if (rsp_log.size() > 0) begin
         e = rsp_log[0];
         check("single_id", 32'(e[31:16]), 32'd2);
         check("single_sum", 32'(e[15:0]), 32'h0007);
      end

      // Full contention held from reset
      for (int i = 0; i < N; i++) set_op(i, W'(i), 16'h0100);
      apply_reset();
      drop_on_grant = 1'b0;
      rsp_log.delete();
      for (int c = 0; c < 40 && rsp_log.size() < 5; c++) tick();
      check("cont_count", 32'(rsp_log.size()), 32'd5);
      for (int k = 0; k < rsp_log.size() && k < 5; k++) begin
         e = rsp_log[k];
         check("cont_id", 32'(e[31:16]), 32'(k % N));
         check("cont_sum", 32'(e[15:0]), 32'(16'h0100 + k % N));
      end
      req_valid = '0;
      drop_on_grant = 1'b1;
      repeat (4) tick();

      // Modulo wrap of the sum
      rsp_log.delete();
      set_op(1, 16'hFFFF, 16'h0002);
      repeat (4) tick();
      set_op(1, 16'h8000, 16'h8000);
      repeat (4) tick();
      check("wrap_count", 32'(rsp_log.size()), 32'd2);
      if (rsp_log.size() == 2) begin
         e = rsp_log[0];
         check("wrap_sum0", 32'(e[15:0]), 32'h0001);
         e = rsp_log[1];
         check("wrap_sum1", 32'(e[15:0]), 32'h0000);
      end

      // Backpressure with another request waiting
      rsp_ready = 1'b0;
      set_op(0, 16'h0005, 16'h0006);
      for (int c = 0; c < 10 && m_st != 2; c++) tick();
      set_op(1, 16'h0007, 16'h0008);
      repeat (10) tick();
      rsp_ready = 1'b1;
      tick();
      tick();
      check("bp_next_busy", 32'(busy), 32'h1);
      repeat (4) tick();

      // Reset while waiting on the adder
      set_op(2, 16'h0009, 16'h0001);
      tick();
      check("mid_in_wait", 32'(busy), 32'h1);
      req_valid = 4'b1000;
      req_a[3*W +: W] = 16'h0011;
      req_b[3*W +: W] = 16'h0022;
      rsp_log.delete();
      apply_reset();
      repeat (4) tick();
      check("mid_count", 32'(rsp_log.size()), 32'd1);
      if (rsp_log.size() > 0) begin
         e = rsp_log[0];
         check("mid_id", 32'(e[31:16]), 32'd3);
         check("mid_sum", 32'(e[15:0]), 32'h0033);
      end
      set_op(0, 16'h0001, 16'h0001);
      set_op(3, 16'h0002, 16'h0002);
      repeat (4) tick();
      req_valid = '0;
      repeat (4) tick();

      // Latency parameter with a three-edge adder
      r3_a[1*W +: W] = 16'h1234;
      r3_b[1*W +: W] = 16'h0101;
      r3_valid = 4'b0010;
      exp3 = W'((32'h1234 + 32'h0101) % 65536);
      t_acc = -1; t_rsp = -1; t_bad = -1;
      s3 = '0; id3 = '0; sbad = exp3;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (r3_ready[1] && t_acc < 0) t_acc = c;
         if (rsp3_valid && t_rsp < 0) begin
            t_rsp = c; s3 = rsp3_sum; id3 = rsp3_id;
         end
         if (db_valid && t_bad < 0) begin
            t_bad = c; sbad = db_sum;
         end
         @(posedge clk);
         #1;
         if (t_acc >= 0) r3_valid = '0;
      end
      check("lat3_cycles", 32'(t_rsp - t_acc), 32'd4);
      check("lat3_sum", 32'(s3), 32'(exp3));
      check("lat3_id", 32'(id3), 32'd1);
      check("lat1_slow_adder_flagged", 32'(sbad != exp3), 32'd1);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(2) == 0)
                  set_op(i, ($urandom_range(3) == 0) ? 16'hFFFF : W'($urandom),
                         W'($urandom));
            end else if ($urandom_range(7) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(3) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 16-bit adder datapath (operands A/B in, sum C out) among NREQ requesters. It accepts one operation at a time from a valid/ready request port, drives the shared adder operands, waits a fixed adder latency, captures the sum, and returns it tagged with the requester ID over a valid/ready response port. It sits between client logic and the adder instance, replacing direct A/B drive.

## Interface
- WIDTH, 16, operand/sum width
- NREQ, 4, number of requesters (2..8)
- ADD_LAT, 1, rising edges from add_a/add_b update to a valid add_c (≥1)
- IDW, $clog2(NREQ), ID width (derived, not overridden)

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- add_a  out  WIDTH  shared adder operand A (registered)
- add_b  out  WIDTH  shared adder operand B (registered)
- add_c  in  WIDTH  shared adder sum
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index of the response
- rsp_sum  out  WIDTH  captured sum
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid is set, the arbiter picks g, the first set bit searching from (last+1) mod NREQ upward with wrap. req_ready[g]=1 combinationally in that cycle; all other bits are 0. This is the handshake.
- On the accept edge:
  - add_a←req_a[g], add_b←req_b[g], rsp_id←g, last←g
  - cnt←ADD_LAT−1
  - state→WAIT
- WAIT: each edge with cnt>0 decrements cnt. On the edge with cnt==0: rsp_sum←add_c, state→RESP.
- RESP: rsp_valid=1, and rsp_id/rsp_sum are held stable. When rsp_valid&rsp_ready, state→IDLE. The next accept is possible at the earliest in the following cycle.
- req_ready is 0 in WAIT and RESP.
- A requester may drop req_valid before it is granted; no commitment exists until the handshake.
- Arithmetic: the sum is modulo 2^WIDTH. Carry-out is discarded by the datapath and not reported.
- last updates only on accept. Requests that do not win are unaffected.
- add_a, add_b and rsp_sum hold their values between operations. They are not cleared on return to IDLE.

## Timing
- Reset (async assert, any state) forces:
  - state=IDLE, cnt=0
  - last=NREQ−1, so requester 0 has first priority
  - add_a=add_b=0, rsp_sum=0, rsp_id=0
  - rsp_valid=0, busy=0, req_ready=0 (until rst_n is high and req_valid is present)
- Reset during WAIT or RESP abandons the in-flight operation. No response is issued.
- Latency: accept in cycle T → rsp_valid first high in cycle T+1+ADD_LAT (ADD_LAT=1: T+2).
- Throughput with rsp_ready tied high: one op per ADD_LAT+2 cycles.
- rsp_valid stays high indefinitely under backpressure. While it is high, rsp_id and rsp_sum must not change.
- add_a/add_b change only on accept edges. They are therefore stable across the whole WAIT window.
- Simultaneous requests: only one grant per accept. Under continuous full load, grant order cycles 0,1,…,NREQ−1,0.

## Test plan
- Single request: req 2 asserts with a=0x0003, b=0x0004, rsp_ready=1 → req_ready[2] high in the same cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_sum=0x0007; busy drops the cycle after the response handshake.
- Contention: all four requesters assert continuously from reset, each with a=i, b=0x0100 → grant order 0,1,2,3,0. Each response carries rsp_id=i, rsp_sum=0x0100+i.
- Wrap-around: a=0xFFFF, b=0x0002 → rsp_sum=0x0001. A new a=0x8000, b=0x8000 → rsp_sum=0x0000.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises → rsp_valid, rsp_id and rsp_sum stay stable; req_ready stays 0 for all requesters. Release → state returns to IDLE, and the next pending request is accepted on the following cycle.
- Reset mid-operation: assert rst_n=0 in WAIT → all outputs are at reset values immediately (asynchronously); no response appears. After release, req 3 pending alone is granted, and with 0 and 3 both pending, 0 wins.
- Latency parameter: ADD_LAT=3, adder model with a 3-edge delay → the response appears exactly 4 cycles after the accept cycle with the correct sum. With ADD_LAT=1 against the same model, the bench flags a mismatch (checker sanity).
